disp_scheduler: RTL and testbench

Time-shares the 3-digit hex 7-segment display between NREQ requesters (CPU result, status, error codes, ...). Each requester raises req with a 12-bit value. The scheduler grants the display round-robin for a fixed hold window and inserts a blank gap between owners. It drives the 12-bit value and blank inputs of the display driver and returns a completion ack to each requester.

---
 rtl/disp_pkg.sv | 20 ++
 rtl/disp_scheduler_rr_arbiter.sv | 36 +++
 rtl/disp_scheduler.sv | 125 ++++++++++++
 tb/tb_disp_scheduler.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// disp_pkg: shared widths, FSM state type and blank value for the display scheduler.
// Revision: 1.0
`default_nettype none

package disp_pkg;

  localparam int DIGITS = 3;
  localparam int VAL_W  = DIGITS * 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [VAL_W-1:0] BLANK_VAL = 12'h000;

endpackage

`default_nettype wire

// File: rtl/disp_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first set request after ptr (cyclic).
// Revision: 1.0
`default_nettype none

module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win_oh,
  output logic [PW-1:0] win_idx,
  output logic          any
);

  logic [PW-1:0] w_j;

  // Scan ptr+1 .. ptr+N so the current pointer holder is considered last.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    any     = 1'b0;
    w_j     = '0;
    for (int k = 1; k <= N; k++) begin
      w_j = PW'((int'(ptr) + k) % N);
      if (!any && req[w_j]) begin
        any         = 1'b1;
        win_oh[w_j] = 1'b1;
        win_idx     = w_j;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/disp_scheduler.sv
// disp_scheduler: round-robin time-sharing of a 3-digit hex display with hold windows and blank gaps.
// Revision: 1.0
`default_nettype none

module disp_scheduler
  import disp_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int HOLD = 1024,
  parameter int GAP  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*VAL_W-1:0] val,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       ack,
  output logic [VAL_W-1:0]      disp_val,
  output logic                  disp_blank,
  output logic                  busy
);

  localparam int PW = $clog2(NREQ);
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [HW-1:0]   r_hold;
  logic [GW-1:0]   r_gap;

  logic [NREQ-1:0] w_win_oh;
  logic [PW-1:0]   w_win_idx;
  logic            w_any;
  logic [VAL_W-1:0] w_win_val;
  logic [VAL_W-1:0] w_own_val;
  logic            w_others;

  rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
    .req     (req),
    .ptr     (r_ptr),
    .win_oh  (w_win_oh),
    .win_idx (w_win_idx),
    .any     (w_any)
  );

  assign w_win_val = val[w_win_idx*VAL_W +: VAL_W];
  assign w_own_val = val[r_ptr*VAL_W +: VAL_W];
  assign w_others  = |(req & ~grant);
  assign busy      = (r_state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= PW'(NREQ - 1);
      r_hold     <= '0;
      r_gap      <= '0;
      grant      <= '0;
      ack        <= '0;
      disp_val   <= BLANK_VAL;
      disp_blank <= 1'b1;
    end else begin
      ack <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state    <= ST_SHOW;
            grant      <= w_win_oh;
            r_ptr      <= w_win_idx;
            r_hold     <= HW'(HOLD - 1);
            disp_val   <= w_win_val;
            disp_blank <= 1'b0;
          end
        end
        ST_SHOW: begin
          if (r_hold == '0) begin
            // Expiry wins over a same-cycle req drop, so the ack is always issued here.
            ack <= grant;
            if (req[r_ptr] && !w_others) begin
              r_hold   <= HW'(HOLD - 1);
              disp_val <= w_own_val;
            end else begin
              r_state    <= ST_GAP;
              grant      <= '0;
              disp_blank <= 1'b1;
              r_gap      <= GW'(GAP - 1);
            end
          end else if (!req[r_ptr]) begin
            r_state    <= ST_GAP;
            grant      <= '0;
            disp_blank <= 1'b1;
            r_gap      <= GW'(GAP - 1);
          end else begin
            r_hold   <= r_hold - 1'b1;
            disp_val <= w_own_val;
          end
        end
        ST_GAP: begin
          if (r_gap == '0) begin
            if (w_any) begin
              r_state    <= ST_SHOW;
              grant      <= w_win_oh;
              r_ptr      <= w_win_idx;
              r_hold     <= HW'(HOLD - 1);
              disp_val   <= w_win_val;
              disp_blank <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_gap <= r_gap - 1'b1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          grant      <= '0;
          disp_blank <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_disp_scheduler.sv
// tb_disp_scheduler: directed self-checking bench, NREQ=4, HOLD=8, GAP=2.
// Revision: 1.0
`default_nettype none

module tb_disp_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [47:0] val;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic [11:0] disp_val;
  logic        disp_blank;
  logic        busy;

  logic [11:0] vals [4];
  int n_cmp;
  int n_err;

  disp_scheduler #(.NREQ(4), .HOLD(8), .GAP(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .val        (val),
    .grant      (grant),
    .ack        (ack),
    .disp_val   (disp_val),
    .disp_blank (disp_blank),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_vals(input logic [11:0] v0, input logic [11:0] v1,
                          input logic [11:0] v2, input logic [11:0] v3);
    vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
    val = {v3, v2, v1, v0};
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req = 4'b0000;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    req = 4'b1111;
    set_vals(12'h123, 12'hABC, 12'h5A5, 12'hF0F);
    rst = 1'b1;
    #2;
    n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant: got %b want 0000", grant); end
    n_cmp++; if (ack !== 4'b0000) begin n_err++; $display("FAIL reset_ack: got %b want 0000", ack); end
    n_cmp++; if (disp_val !== 12'h000) begin n_err++; $display("FAIL reset_val: got %h want 000", disp_val); end
    n_cmp++; if (disp_blank !== 1'b1) begin n_err++; $display("FAIL reset_blank: got %b want 1", disp_blank); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  // Single continuous requester: ack every 8 cycles, grant never drops.
  task automatic test_extension;
    logic [3:0] e_ack;
    do_reset;
    set_vals(12'h123, 12'hABC, 12'h5A5, 12'hF0F);
    req = 4'b0001;
    for (int c = 1; c <= 18; c++) begin
      tick;
      e_ack = (c == 9 || c == 17) ? 4'b0001 : 4'b0000;
      n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL ext_grant c=%0d: got %b want 0001", c, grant); end
      n_cmp++; if (disp_val !== 12'h123) begin n_err++; $display("FAIL ext_val c=%0d: got %h want 123", c, disp_val); end
      n_cmp++; if (disp_blank !== 1'b0) begin n_err++; $display("FAIL ext_blank c=%0d: got %b want 0", c, disp_blank); end
      n_cmp++; if (ack !== e_ack) begin n_err++; $display("FAIL ext_ack c=%0d: got %b want %b", c, ack, e_ack); end
    end
  endtask

  // Contended windows: 8 SHOW cycles, then 2 blank cycles, ack on the first blank one.
  task automatic run_windows(input string tag, input logic [3:0] reqs,
                             input int nwin, input logic [15:0] ord);
    int k, p;
    logic [1:0]  own;
    logic [3:0]  e_grant, e_ack;
    logic        e_blank;
    do_reset;
    set_vals(12'h123, 12'hABC, 12'h5A5, 12'hF0F);
    req = reqs;
    for (int c = 1; c <= nwin * 10 - 1; c++) begin
      tick;
      k = (c - 1) / 10;
      p = (c - 1) % 10;
      own = ord[2*k +: 2];
      e_grant = (p < 8) ? (4'b0001 << own) : 4'b0000;
      e_ack   = (p == 8) ? (4'b0001 << own) : 4'b0000;
      e_blank = (p >= 8);
      n_cmp++; if (grant !== e_grant) begin n_err++; $display("FAIL %s_grant c=%0d: got %b want %b", tag, c, grant, e_grant); end
      n_cmp++; if (ack !== e_ack) begin n_err++; $display("FAIL %s_ack c=%0d: got %b want %b", tag, c, ack, e_ack); end
      n_cmp++; if (disp_blank !== e_blank) begin n_err++; $display("FAIL %s_blank c=%0d: got %b want %b", tag, c, disp_blank, e_blank); end
      if (p < 8) begin
        n_cmp++; if (disp_val !== vals[own]) begin n_err++; $display("FAIL %s_val c=%0d: got %h want %h", tag, c, disp_val, vals[own]); end
      end
    end
  endtask

  task automatic test_two_req;
    run_windows("two", 4'b0011, 3, {10'd0, 2'd0, 2'd1, 2'd0});
  endtask

  task automatic test_all_req;
    run_windows("all", 4'b1111, 5, {6'd0, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0});
  endtask

  task automatic test_early_drop;
    do_reset;
    set_vals(12'h123, 12'hABC, 12'h5A5, 12'hF0F);
    req = 4'b0100;
    for (int c = 1; c <= 3; c++) begin
      tick;
      n_cmp++; if (grant !== 4'b0100) begin n_err++; $display("FAIL drop_grant c=%0d: got %b want 0100", c, grant); end
    end
    req = 4'b0000;
    tick;
    n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL drop_gap_grant: got %b want 0000", grant); end
    n_cmp++; if (disp_blank !== 1'b1) begin n_err++; $display("FAIL drop_gap_blank: got %b want 1", disp_blank); end
    n_cmp++; if (ack !== 4'b0000) begin n_err++; $display("FAIL drop_ack1: got %b want 0000", ack); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL drop_busy1: got %b want 1", busy); end
    tick;
    n_cmp++; if (ack !== 4'b0000) begin n_err++; $display("FAIL drop_ack2: got %b want 0000", ack); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL drop_busy2: got %b want 1", busy); end
    tick;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL drop_idle_busy: got %b want 0", busy); end
    n_cmp++; if (ack !== 4'b0000) begin n_err++; $display("FAIL drop_ack3: got %b want 0000", ack); end
    n_cmp++; if (disp_blank !== 1'b1) begin n_err++; $display("FAIL drop_idle_blank: got %b want 1", disp_blank); end
  endtask

  task automatic test_val_change;
    do_reset;
    set_vals(12'h111, 12'hABC, 12'h5A5, 12'hF0F);
    req = 4'b0001;
    for (int c = 1; c <= 3; c++) tick;
    n_cmp++; if (disp_val !== 12'h111) begin n_err++; $display("FAIL valchg_before: got %h want 111", disp_val); end
    set_vals(12'h222, 12'hABC, 12'h5A5, 12'hF0F);
    #1;
    n_cmp++; if (disp_val !== 12'h111) begin n_err++; $display("FAIL valchg_same_cycle: got %h want 111", disp_val); end
    tick;
    n_cmp++; if (disp_val !== 12'h222) begin n_err++; $display("FAIL valchg_after: got %h want 222", disp_val); end
    n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL valchg_grant: got %b want 0001", grant); end
  endtask

  // Reset lands in the last SHOW cycle, so the pending ack must vanish.
  task automatic test_reset_mid;
    do_reset;
    set_vals(12'h123, 12'hABC, 12'h5A5, 12'hF0F);
    req = 4'b0001;
    for (int c = 1; c <= 8; c++) tick;
    #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL rstmid_grant: got %b want 0000", grant); end
    n_cmp++; if (disp_blank !== 1'b1) begin n_err++; $display("FAIL rstmid_blank: got %b want 1", disp_blank); end
    n_cmp++; if (disp_val !== 12'h000) begin n_err++; $display("FAIL rstmid_val: got %h want 000", disp_val); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    req = 4'b1000;
    @(posedge clk);
    #1;
    n_cmp++; if (ack !== 4'b0000) begin n_err++; $display("FAIL rstmid_ack_lost: got %b want 0000", ack); end
    rst = 1'b0;
    tick;
    n_cmp++; if (grant !== 4'b1000) begin n_err++; $display("FAIL rstmid_regrant: got %b want 1000", grant); end
    n_cmp++; if (disp_val !== 12'hF0F) begin n_err++; $display("FAIL rstmid_regrant_val: got %h want f0f", disp_val); end
    n_cmp++; if (ack !== 4'b0000) begin n_err++; $display("FAIL rstmid_ack: got %b want 0000", ack); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    req = 4'b0000;
    val = '0;
    test_reset;
    test_extension;
    test_two_req;
    test_all_req;
    test_early_drop;
    test_val_change;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
